// File: rtl/cpu_bus_pkg.sv
// Shared defaults, FSM state encoding and response-entry layout for the
// SRAM-like core to split-transaction bus bridge.
package cpu_bus_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2
    } bridge_state_t;

    typedef struct packed {
        logic [DEFAULT_DATA_W-1:0] rdata;
        logic                      wr;
    } rsp_entry_t;

endpackage

// File: rtl/bridge_rsp_fifo.sv
// Small synchronous FIFO with async reset and a synchronous flush; used both
// for the in-order request tags and for buffered core responses.
module bridge_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_bridge.sv
// Bridges an SRAM-like core port onto an addr_ok/data_ok bus with in-order responses.
// Optional cancel/flush support is compiled in when BRIDGE_CANCEL_EN is defined.
module sram_like_bridge
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       core_req_valid,
    output logic                       core_req_ready,
    input  logic                       core_req_wr,
    input  logic [DATA_W/8-1:0]        core_req_wstrb,
    input  logic [ADDR_W-1:0]          core_req_addr,
    input  logic [DATA_W-1:0]          core_req_wdata,
    output logic                       core_rsp_valid,
    input  logic                       core_rsp_ready,
    output logic [DATA_W-1:0]          core_rsp_rdata,
    output logic                       core_rsp_wr,
    output logic                       bus_req,
    output logic                       bus_wr,
    output logic [DATA_W/8-1:0]        bus_wstrb,
    output logic [ADDR_W-1:0]          bus_addr,
    output logic [DATA_W-1:0]          bus_wdata,
    input  logic                       bus_addr_ok,
    input  logic                       bus_data_ok,
    input  logic [DATA_W-1:0]          bus_rdata,
    input  logic                       cancel,
    output logic [$clog2(DEPTH+1)-1:0] inflight,
    output bridge_state_t              state
);

    localparam int             IW      = $clog2(DEPTH + 1);
    localparam logic [IW:0]    DEPTH_V = (IW + 1)'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              wr;
    } rsp_t;

    logic [IW-1:0] rsp_count;
    logic          rsp_empty;
    logic          rsp_push;
    logic          rsp_pop;
    logic          rsp_flush;
    rsp_t          rsp_head;
    rsp_t          rsp_push_data;
    logic          tag_wr;
    logic          accept;
    logic          data_counted;
    logic          credit_ok;
    logic [IW:0]   used;
    logic [IW-1:0] inflight_next;
    logic [IW-1:0] tag_count_unused;
    logic          tag_empty_unused;
    logic          tag_full_unused;
    logic          rsp_full_unused;

`ifdef BRIDGE_CANCEL_EN
    logic [IW-1:0] discard;
    assign rsp_flush = cancel;
`else
    logic cancel_unused;
    assign cancel_unused = cancel;
    assign rsp_flush     = 1'b0;
`endif

    // Credits cover both outstanding bus requests and buffered responses, so
    // the response FIFO can never be asked to hold more than DEPTH entries.
    assign used      = {1'b0, inflight} + {1'b0, rsp_count};
    assign credit_ok = (used < DEPTH_V);

    // Handshakes: a request transfers when bus_req && bus_addr_ok (mirrored on
    // core_req_ready); a response transfers on a clock edge where
    // core_rsp_valid && core_rsp_ready. Valid never depends on ready.
    assign bus_req        = !reset && core_req_valid && credit_ok && !rsp_flush
                            && (state != FLUSH);
    assign accept         = bus_req && bus_addr_ok;
    assign core_req_ready = accept;

    assign bus_wr    = core_req_wr;
    assign bus_wstrb = core_req_wstrb;
    assign bus_addr  = core_req_addr;
    assign bus_wdata = core_req_wdata;

    // data_ok with nothing outstanding is a stray pulse and is dropped.
    assign data_counted        = bus_data_ok && (inflight != '0);
    assign rsp_push            = data_counted && (state != FLUSH) && !rsp_flush;
    assign rsp_push_data.rdata = tag_wr ? '0 : bus_rdata;
    assign rsp_push_data.wr    = tag_wr;

    assign core_rsp_valid = !rsp_empty;
    assign rsp_pop        = core_rsp_valid && core_rsp_ready;
    assign core_rsp_rdata = core_rsp_valid ? rsp_head.rdata : '0;
    assign core_rsp_wr    = core_rsp_valid && rsp_head.wr;

    bridge_rsp_fifo #(
        .WIDTH (1),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (accept),
        .push_data (core_req_wr),
        .pop       (data_counted),
        .pop_data  (tag_wr),
        .count     (tag_count_unused),
        .empty     (tag_empty_unused),
        .full      (tag_full_unused)
    );

    bridge_rsp_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (rsp_flush),
        .push      (rsp_push),
        .push_data (rsp_push_data),
        .pop       (rsp_pop),
        .pop_data  (rsp_head),
        .count     (rsp_count),
        .empty     (rsp_empty),
        .full      (rsp_full_unused)
    );

    always_comb begin
        inflight_next = inflight;
        if (accept && !data_counted) begin
            inflight_next = inflight + IW'(1);
        end else if (!accept && data_counted) begin
            inflight_next = inflight - IW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= '0;
            state    <= IDLE;
`ifdef BRIDGE_CANCEL_EN
            discard  <= '0;
`endif
        end else begin
            inflight <= inflight_next;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (inflight_next == '0) begin
                        state <= IDLE;
                    end
                end
                FLUSH: begin
`ifdef BRIDGE_CANCEL_EN
                    if (data_counted) begin
                        discard <= discard - IW'(1);
                    end
                    if (data_counted && (discard == IW'(1))) begin
                        state <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
`ifdef BRIDGE_CANCEL_EN
            // Cancel overrides the normal transitions; every request still on
            // the bus (after this cycle's data_ok) must be swallowed.
            if (cancel) begin
                discard <= inflight_next;
                state   <= (inflight_next != '0) ? FLUSH : IDLE;
            end
`endif
        end
    end

endmodule
